// File: rtl/arbitro_escrita_registradores.sv
// Write-back arbiter for the register bank's single write port, with a pending-write
// scoreboard that raises a read-hazard stall for decode.
module arbitro_escrita_registradores #(
    parameter int BITS = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            a_valid,
    output logic            a_ready,
    input  logic [4:0]      a_rd,
    input  logic [BITS-1:0] a_data,
    input  logic            b_valid,
    output logic            b_ready,
    input  logic [4:0]      b_rd,
    input  logic [BITS-1:0] b_data,
    input  logic            res_valid,
    input  logic [4:0]      res_rd,
    input  logic [4:0]      Ra,
    input  logic [4:0]      Rb,
    output logic            stall,
    output logic            rf_we,
    output logic [4:0]      rf_rw,
    output logic [BITS-1:0] rf_din
);

    logic [31:0] r_pend;
    logic        r_last_b;
    logic [31:0] w_pend_next;
    logic        w_grant_a;
    logic        w_grant_b;

    // On conflict the requester that did not win last time gets the port.
    assign w_grant_a = a_valid && (!b_valid || r_last_b);
    assign w_grant_b = b_valid && (!a_valid || !r_last_b);
    assign a_ready   = w_grant_a;
    assign b_ready   = w_grant_b;

    assign stall = ((Ra != 5'd0) && r_pend[Ra]) || ((Rb != 5'd0) && r_pend[Rb]);

    // Clear is applied first so a new producer marking the same register wins.
    always_comb begin
        w_pend_next = r_pend;
        if (rf_we) begin
            w_pend_next[rf_rw] = 1'b0;
        end
        if (res_valid && (res_rd != 5'd0)) begin
            w_pend_next[res_rd] = 1'b1;
        end
        w_pend_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_rw    <= 5'd0;
            rf_din   <= '0;
            r_pend   <= 32'd0;
            r_last_b <= 1'b1;
        end else begin
            r_pend <= w_pend_next;
            if (w_grant_a) begin
                rf_we    <= (a_rd != 5'd0);
                rf_rw    <= a_rd;
                rf_din   <= a_data;
                r_last_b <= 1'b0;
            end else if (w_grant_b) begin
                rf_we    <= (b_rd != 5'd0);
                rf_rw    <= b_rd;
                rf_din   <= b_data;
                r_last_b <= 1'b1;
            end else begin
                rf_we <= 1'b0;
            end
        end
    end

endmodule
